// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Read hits are served combinationally; read misses and all stores stall until memory completes.
module dcache_ctrl #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int SET_WIDTH     = 3,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   input  logic                     req_we,
   input  logic [ADDRESS_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0]    req_wdata,
   output logic [DATA_WIDTH-1:0]    rdata,
   output logic                     stall,
   input  logic                     flush,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   input  logic                     mem_ready,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   output logic [CNT_WIDTH-1:0]     hit_cnt,
   output logic [CNT_WIDTH-1:0]     miss_cnt
);

   localparam int NUM_SETS  = 1 << SET_WIDTH;
   localparam int TAG_WIDTH = ADDRESS_WIDTH - SET_WIDTH - 2;
   localparam logic [ADDRESS_WIDTH-1:0] WORD_MASK = {{(ADDRESS_WIDTH-2){1'b1}}, 2'b00};

   typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, DONE} state_t;

   state_t state, nextState;

   logic [DATA_WIDTH-1:0] lineData [NUM_SETS];
   logic [TAG_WIDTH-1:0]  lineTag  [NUM_SETS];
   logic [NUM_SETS-1:0]   lineValid;
   logic                  flushPend;

   logic [SET_WIDTH-1:0]  reqIndex, heldIndex;
   logic [TAG_WIDTH-1:0]  reqTag, heldTag;
   logic                  reqHit, heldHit;
   logic                  latchReq, fillLine, updateLine, countHit, countMiss, clearValid;

   assign reqIndex  = req_addr[SET_WIDTH+1:2];
   assign reqTag    = req_addr[ADDRESS_WIDTH-1:SET_WIDTH+2];
   // The in-flight transaction is tracked through the latched mem_addr, not the live request.
   assign heldIndex = mem_addr[SET_WIDTH+1:2];
   assign heldTag   = mem_addr[ADDRESS_WIDTH-1:SET_WIDTH+2];
   assign reqHit    = lineValid[reqIndex] && (lineTag[reqIndex] == reqTag);
   assign heldHit   = lineValid[heldIndex] && (lineTag[heldIndex] == heldTag);

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      nextState  = state;
      stall      = 1'b0;
      rdata      = '0;
      latchReq   = 1'b0;
      fillLine   = 1'b0;
      updateLine = 1'b0;
      countHit   = 1'b0;
      countMiss  = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               if (!req_we && reqHit) begin
                  rdata    = lineData[reqIndex];
                  countHit = 1'b1;
               end else begin
                  stall    = 1'b1;
                  latchReq = 1'b1;
                  if (req_we) begin
                     nextState = WR_THRU;
                  end else begin
                     nextState = RD_MISS;
                     countMiss = 1'b1;
                  end
               end
            end
         end
         RD_MISS: begin
            stall = 1'b1;
            if (mem_ready) begin
               fillLine  = 1'b1;
               nextState = DONE;
            end
         end
         WR_THRU: begin
            stall = 1'b1;
            if (mem_ready) begin
               updateLine = heldHit;
               nextState  = DONE;
            end
         end
         DONE: begin
            if (req_valid && !mem_we) rdata = lineData[heldIndex];
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
      if (!rst) begin
         stall = 1'b0;
         rdata = '0;
      end
   end

   assign clearValid = ((state == IDLE) && flush) || ((state == DONE) && (flushPend || flush));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         lineValid <= '0;
         flushPend <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
      end else begin
         state   <= nextState;
         mem_req <= (nextState == RD_MISS) || (nextState == WR_THRU);
         if (latchReq) begin
            mem_we    <= req_we;
            mem_addr  <= req_addr & WORD_MASK;
            mem_wdata <= req_wdata;
         end
         if (clearValid) lineValid <= '0;
         else if (fillLine) lineValid[heldIndex] <= 1'b1;
         if (state == DONE) flushPend <= 1'b0;
         else if (flush && (state != IDLE)) flushPend <= 1'b1;
         if (countHit) hit_cnt <= hit_cnt + CNT_WIDTH'(1);
         if (countMiss) miss_cnt <= miss_cnt + CNT_WIDTH'(1);
      end
   end

   // NOTE: data and tag arrays carry no reset; the valid bits alone decide whether a line is usable.
   always_ff @(posedge clk) begin
      if (fillLine) begin
         lineData[heldIndex] <= mem_rdata;
         lineTag[heldIndex]  <= heldTag;
      end else if (updateLine) begin
         lineData[heldIndex] <= mem_wdata;
      end
   end

endmodule
